// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit for the E stage. Owns the HI/LO register
//   pair. A long operation (MULT/MULTU/DIV/DIVU, and MADD when enabled)
//   computes its 64-bit result at issue, holds it in a pending buffer, and
//   writes it to HI/LO after the configured number of busy cycles. MTHI/MTLO
//   write HI/LO directly at issue and never go busy.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : MDUOP 7 (MADD) accumulates the signed product into {HI,LO}.
//   undefined : MDUOP 7 is treated as no operation.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>=1)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; clears HI/LO and any pending op
//   Start     in   qualifies MDUOP this cycle
//   MDUOP     in   [3:0] 1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD
//   A, B      in   [31:0] rs / rt operands
//   ReadHILO  in   [1:0] 1 selects HI, 2 selects LO
//   Busy      out  high while running, and in the issue cycle of a long op
//   HILOOut   out  [31:0] committed HI or LO, else 0
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  ReadHILO,
  output logic        Busy,
  output logic [31:0] HILOOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_CYCLES - 1);

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case
  // (magnitude 0x80000000 is representable unsigned). Returns {rem, quo};
  // quotient truncates toward zero, remainder takes the sign of a.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u, qr_s, qr_u;
  logic               long_op, issue, commit;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign qr_s   = div_signed(A, B);
  assign qr_u   = div_unsigned(A, B);

  always_comb begin
    long_op = 1'b0;
    case (MDUOP)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  assign issue  = Start & ~busy_q & long_op;
  assign commit = busy_q & (cnt_q == '0);

  // State register: control and datapath both clear on reset, so a reset
  // during RUN discards the pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  // Next state: IDLE -> RUN on issue with cnt = N-1; RUN -> IDLE when cnt hits 0.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (issue) begin
        busy_d = 1'b1;
        cnt_d  = ((MDUOP == OP_DIV) || (MDUOP == OP_DIVU)) ? DIV_CNT0 : MUL_CNT0;
      end
    end else if (cnt_q == '0) begin
      busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // HI/LO and pending result. res_wr marks whether the pending result is
  // real; a divide by zero runs the full time but leaves HI/LO untouched.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    if (commit) begin
      if (res_wr_q) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
      res_wr_d = 1'b0;
    end else if (!busy_q && Start) begin
      case (MDUOP)
        OP_MULT: begin
          {res_hi_d, res_lo_d} = $unsigned(prod_s);
          res_wr_d = 1'b1;
        end
        OP_MULTU: begin
          {res_hi_d, res_lo_d} = prod_u;
          res_wr_d = 1'b1;
        end
        OP_DIV: begin
          {res_hi_d, res_lo_d} = qr_s;
          res_wr_d = (B != 32'd0);
        end
        OP_DIVU: begin
          {res_hi_d, res_lo_d} = qr_u;
          res_wr_d = (B != 32'd0);
        end
`ifdef MDU_MADD_EN
        OP_MADD: begin
          // Addend is the committed HI/LO at issue time.
          {res_hi_d, res_lo_d} = {hi_q, lo_q} + $unsigned(prod_s);
          res_wr_d = 1'b1;
        end
`endif
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  // Outputs: Busy asserts combinationally in the issue cycle so the next
  // MD instruction stalls; HILOOut only ever shows committed HI/LO.
  always_comb begin
    Busy = (Start & long_op) | busy_q;
    case (ReadHILO)
      2'd1:    HILOOut = hi_q;
      2'd2:    HILOOut = lo_q;
      default: HILOOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [31:0] A, B;
  logic [1:0]  ReadHILO;
  logic        Busy;
  logic [31:0] HILOOut;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit armed     = 1'b0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOP(MDUOP), .A(A), .B(B),
    .ReadHILO(ReadHILO), .Busy(Busy), .HILOOut(HILOOut)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit is_long(logic [3:0] op);
    bit r;
    r = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
    if (op == 4'd7) r = 1'b1;
`endif
    return r;
  endfunction

  // Reference model: committed HI/LO plus a pending result that lands at an
  // absolute edge number. Busy is simply "edge count below completion edge".
  logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;
  bit          m_pend = 0;
  int          e = 0, m_done = 0;

  always @(posedge clk) begin
    bit busy_b;
    longint q, r;
    logic [63:0] w;
    busy_b = (e < m_done);
    e++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_done = 0;
    end else if (busy_b) begin
      if (e == m_done && m_pend) begin
        m_hi = m_rhi; m_lo = m_rlo; m_pend = 0;
      end
    end else if (Start) begin
      case (MDUOP)
        4'd1: begin
          w = 64'(longint'($signed(A)) * longint'($signed(B)));
          {m_rhi, m_rlo} = w; m_pend = 1; m_done = e + MULT_N;
        end
        4'd2: begin
          w = {32'd0, A} * {32'd0, B};
          {m_rhi, m_rlo} = w; m_pend = 1; m_done = e + MULT_N;
        end
        4'd3: begin
          m_pend = (B != 0);
          if (m_pend) begin
            q = longint'($signed(A)) / longint'($signed(B));
            r = longint'($signed(A)) % longint'($signed(B));
            m_rlo = q[31:0]; m_rhi = r[31:0];
          end
          m_done = e + DIV_N;
        end
        4'd4: begin
          m_pend = (B != 0);
          if (m_pend) begin m_rlo = A / B; m_rhi = A % B; end
          m_done = e + DIV_N;
        end
        4'd5: m_hi = A;
        4'd6: m_lo = A;
`ifdef MDU_MADD_EN
        4'd7: begin
          w = {m_hi, m_lo} + 64'(longint'($signed(A)) * longint'($signed(B)));
          {m_rhi, m_rlo} = w; m_pend = 1; m_done = e + MULT_N;
        end
`endif
        default: ;
      endcase
    end
  end

  // Compare process: every cycle once out of reset.
  always @(negedge clk) begin
    logic [31:0] exp_hilo;
    if (armed) begin
      exp_hilo = (ReadHILO == 2'd1) ? m_hi : (ReadHILO == 2'd2) ? m_lo : 32'd0;
      chk("busy", 32'(Busy), 32'(((e < m_done) || (Start && is_long(MDUOP))) ? 1 : 0));
      chk("hilo", HILOOut, exp_hilo);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDUOP = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ReadHILO = (i % 2 == 0) ? 2'd1 : 2'd2;
    end
  endtask

  task automatic read_lit(input string name, input logic [1:0] sel, input logic [31:0] exp);
    ReadHILO = sel; #1;
    chk(name, HILOOut, exp);
  endtask

  task automatic count_busy(input string name, input int n, input int exp);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Busy) c++;
    end
    chk(name, 32'(c), 32'(exp));
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t tbl[6];

  initial begin
    Start = 0; MDUOP = 0; A = 0; B = 0; ReadHILO = 0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; armed = 1'b1;
    chk("rst_busy", 32'(Busy), 32'h0);
    read_lit("rst_hi", 2'd1, 32'h0);
    read_lit("rst_lo", 2'd2, 32'h0);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    count_busy("mult_busy_len", 8, 5);
    read_lit("mult_hi", 2'd1, 32'hFFFFFFFF);
    read_lit("mult_lo", 2'd2, 32'hFFFFFFFA);

    // MULTU max*max; LO read mid-run shows old value
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_lit("multu_run_lo", 2'd2, 32'hFFFFFFFA);
    idle(6);
    read_lit("multu_hi", 2'd1, 32'hFFFFFFFE);
    read_lit("multu_lo", 2'd2, 32'h00000001);

    // DIV -7 / 2
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    idle(11);
    read_lit("div_lo", 2'd2, 32'hFFFFFFFD);
    read_lit("div_hi", 2'd1, 32'hFFFFFFFF);

    // DIVU 7 / 0: full busy, HI/LO unchanged
    issue(4'd4, 32'd7, 32'd0);
    count_busy("divz_busy_len", 13, 10);
    read_lit("divz_hi", 2'd1, 32'hFFFFFFFF);
    read_lit("divz_lo", 2'd2, 32'hFFFFFFFD);

    // DIV overflow corner
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(11);
    read_lit("divov_lo", 2'd2, 32'h80000000);
    read_lit("divov_hi", 2'd1, 32'h00000000);

    // MTHI: never busy, visible next cycle
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = 4'd5; A = 32'h12345678;
    #1 chk("mthi_busy", 32'(Busy), 32'h0);
    @(posedge clk); #1;
    Start = 1'b0; MDUOP = 4'd0;
    read_lit("mthi_hi", 2'd1, 32'h12345678);
    issue(4'd6, 32'hCAFEBABE, 32'd0);
    read_lit("mtlo_lo", 2'd2, 32'hCAFEBABE);

    // DIV presented while MULT runs is ignored
    issue(4'd1, 32'd100, 32'd7);
    @(posedge clk); #1;
    Start = 1'b1; MDUOP = 4'd3; A = 32'd50; B = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0; MDUOP = 4'd0;
    idle(14);
    read_lit("ign_lo", 2'd2, 32'h000002BC);
    read_lit("ign_hi", 2'd1, 32'h00000000);

    // Assorted directed vectors, checked by the model
    tbl[0] = '{4'd1, 32'h80000000, 32'h80000000};
    tbl[1] = '{4'd3, 32'h00000007, 32'hFFFFFFFE};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE};
    tbl[3] = '{4'd4, 32'hFFFFFFFF, 32'h00000010};
    tbl[4] = '{4'd2, 32'h80000000, 32'h00000002};
    tbl[5] = '{4'd3, 32'h00000005, 32'h00000000};
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      idle(DIV_N + 2);
    end

    // No-op codes leave state alone
    issue(4'd5, 32'h11111111, 32'd0);
    issue(4'd6, 32'h22222222, 32'd0);
    for (int op = 8; op < 16; op++) issue(4'(op), 32'hDEADBEEF, 32'd1);
    issue(4'd0, 32'hDEADBEEF, 32'd1);
    idle(2);
    read_lit("nop_hi", 2'd1, 32'h11111111);
    read_lit("nop_lo", 2'd2, 32'h22222222);

    // MADD
    issue(4'd5, 32'h0, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    issue(4'd7, 32'd1, 32'd1);
    idle(6);
    read_lit("madd_hi", 2'd1, 32'h00000001);
    read_lit("madd_lo", 2'd2, 32'h00000000);
`else
    issue(4'd7, 32'd1, 32'd1);
    count_busy("madd_off_busy", 6, 0);
    read_lit("madd_off_hi", 2'd1, 32'h00000000);
    read_lit("madd_off_lo", 2'd2, 32'hFFFFFFFF);
`endif

    // Reset at cycle 3 of a DIV
    issue(4'd5, 32'hAAAA5555, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstrun_busy", 32'(Busy), 32'h0);
    read_lit("rstrun_hi", 2'd1, 32'h0);
    read_lit("rstrun_lo", 2'd2, 32'h0);
    idle(12);
    read_lit("rstrun_lo_late", 2'd2, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
